// File: rtl/pl_spi_dds_pkg.sv
// Shared definitions for the PL SPI DDS register block: register map,
// AXI response codes, FSM state types and the byte-strobe merge helper.
package pl_spi_dds_pkg;

  localparam int NUM_REGS = 4;

  // Register indices (ADDR[3:2])
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_FTW      = 2'd1;
  localparam logic [1:0] REG_PHASE    = 2'd2;
  localparam logic [1:0] REG_SPI_DATA = 2'd3;

  // Byte offsets on the AXI address bus
  localparam logic [3:0] OFF_CTRL     = 4'h0;
  localparam logic [3:0] OFF_FTW      = 4'h4;
  localparam logic [3:0] OFF_PHASE    = 4'h8;
  localparam logic [3:0] OFF_SPI_DATA = 4'hC;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // Replace each byte of old whose strobe is set with the matching wdata byte.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pl_spi_dds_axil_regs.sv
// AXI4-Lite slave holding the four SPI/DDS control registers. Write and read
// paths are independent two-state FSMs; every output comes straight from a flop.
module pl_spi_dds_axil_regs
  import pl_spi_dds_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [31:0]                       ctrl_o,
  output logic [31:0]                       ftw_o,
  output logic [31:0]                       phase_o,
  output logic [31:0]                       spi_data_o,
  output logic [NUM_REGS-1:0]               reg_wr_pulse_o
);

  // Register file
  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;

  // Write path state
  wstate_t       wstate_q, wstate_d;
  logic          aw_held_q, aw_held_d;
  logic          w_held_q, w_held_d;
  logic [1:0]    awidx_q, awidx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;

  // Read path state
  rstate_t       rstate_q, rstate_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          aw_hs, w_hs, ar_hs;
  logic [1:0]    wr_idx;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;

  // Protection bits and the byte-lane address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID  && wready_q;
  assign ar_hs = S_AXI_ARVALID && arready_q;

  // A half arriving this cycle takes precedence over the latched copy
  // (the two can never both be valid: READY is low while a half is held).
  assign wr_idx  = aw_hs ? S_AXI_AWADDR[3:2] : awidx_q;
  assign wr_data = w_hs  ? S_AXI_WDATA       : wdata_q;
  assign wr_strb = w_hs  ? S_AXI_WSTRB       : wstrb_q;

  // Write FSM: collect AW and W in any order, commit when both are present.
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    pulse_d   = '0;
    regs_d    = regs_q;
    case (wstate_q)
      W_IDLE: begin
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          regs_d[wr_idx]  = apply_wstrb(regs_q[wr_idx], wr_data, wr_strb);
          pulse_d[wr_idx] = 1'b1;
          bvalid_d        = 1'b1;
          wstate_d        = W_RESP;
          aw_held_d       = 1'b0;
          w_held_d        = 1'b0;
          awready_d       = 1'b0;
          wready_d        = 1'b0;
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            awidx_d   = S_AXI_AWADDR[3:2];
            awready_d = 1'b0;
          end else if (!aw_held_q) begin
            awready_d = 1'b1;
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
            wready_d = 1'b0;
          end else if (!w_held_q) begin
            wready_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          wstate_d  = W_IDLE;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read FSM: capture the selected register on AR, hold until RREADY.
  // regs_q is the pre-commit value, so a same-cycle write is not seen.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rdata_d   = regs_q[S_AXI_ARADDR[3:2]];
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rstate_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Write-path and register-file flops
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      pulse_q   <= '0;
      regs_q    <= '0;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
    end
  end

  // Read-path flops
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY  = awready_q;
  assign S_AXI_WREADY   = wready_q;
  assign S_AXI_BVALID   = bvalid_q;
  assign S_AXI_BRESP    = AXI_RESP_OKAY;
  assign S_AXI_ARREADY  = arready_q;
  assign S_AXI_RVALID   = rvalid_q;
  assign S_AXI_RDATA    = rdata_q;
  assign S_AXI_RRESP    = AXI_RESP_OKAY;

  assign ctrl_o         = regs_q[REG_CTRL];
  assign ftw_o          = regs_q[REG_FTW];
  assign phase_o        = regs_q[REG_PHASE];
  assign spi_data_o     = regs_q[REG_SPI_DATA];
  assign reg_wr_pulse_o = pulse_q;

endmodule
